pwm_capture: RTL and testbench

Multi-channel PWM duty-cycle measurement block: the receive-side counterpart of the team's serial-loaded PWM generator. It samples CHANNELS PWM waveforms over fixed windows of 2^WIDTH clocks. At the end of each window it publishes one WIDTH-bit duty value per channel. It is used in loopback to check generator outputs on silicon and in simulation, and as a general PWM input stage.

---
 rtl/pwm_capture.sv | 91 +++++++++
 tb/tb_pwm_capture.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// Multi-channel PWM duty-cycle capture: counts synchronized high samples per
// channel over free-running 2^WIDTH-clock windows and publishes saturated duty values.
module pwm_capture #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [CHANNELS-1:0]       pwm_in,
  output logic [CHANNELS*WIDTH-1:0] duty,
  output logic                      frame_valid,
  output logic [CHANNELS-1:0]       changed
);

  typedef enum logic {
    IDLE,
    COUNT
  } state_t;

  localparam logic [WIDTH-1:0] FRAME_LAST = '1;
  localparam logic [WIDTH:0]   DUTY_MAX   = {1'b0, {WIDTH{1'b1}}};

  state_t              state;
  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;
  logic [WIDTH-1:0]    frame_cnt;
  logic [WIDTH:0]      high_cnt [CHANNELS];
  logic [WIDTH:0]      total    [CHANNELS];
  logic [WIDTH-1:0]    new_duty [CHANNELS];

  // NOTE: every always_comb output is assigned on every path (here, every loop
  // iteration unconditionally), so no latch can be inferred.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      total[i]    = high_cnt[i] + {{WIDTH{1'b0}}, sync2[i]};
      // A channel high for the whole window counts 2^WIDTH, which saturates.
      new_duty[i] = (total[i] > DUTY_MAX) ? FRAME_LAST : total[i][WIDTH-1:0];
    end
  end

  // NOTE: all state here is sequential, so only non-blocking assignments are
  // used; mixing in blocking ones would create simulation/synthesis races.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= '0;
      sync2       <= '0;
      state       <= IDLE;
      frame_cnt   <= '0;
      duty        <= '0;
      changed     <= '0;
      frame_valid <= 1'b0;
      // NOTE: high_cnt is a small flop array, not a RAM macro, so it can and
      // must be cleared element by element on reset.
      for (int i = 0; i < CHANNELS; i++) high_cnt[i] <= '0;
    end else begin
      sync1       <= pwm_in;
      sync2       <= sync1;
      frame_valid <= 1'b0;
      case (state)
        IDLE: begin
          frame_cnt <= '0;
          for (int i = 0; i < CHANNELS; i++) high_cnt[i] <= '0;
          if (enable) state <= COUNT;
        end
        COUNT: begin
          if (!enable) begin
            // Dropping enable discards the partial window; duty/changed hold.
            state     <= IDLE;
            frame_cnt <= '0;
            for (int i = 0; i < CHANNELS; i++) high_cnt[i] <= '0;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
            if (frame_cnt == FRAME_LAST) begin
              frame_valid <= 1'b1;
              for (int i = 0; i < CHANNELS; i++) begin
                duty[i*WIDTH +: WIDTH] <= new_duty[i];
                changed[i]             <= (new_duty[i] != duty[i*WIDTH +: WIDTH]);
                high_cnt[i]            <= '0;
              end
            end else begin
              for (int i = 0; i < CHANNELS; i++) high_cnt[i] <= total[i];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: directed scenarios with random content,
// checked every cycle against a window-sum reference model over stimulus history.
module tb_pwm_capture;

  localparam int W = 8;
  localparam int C = 8;
  localparam int P = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [C-1:0] pwm_in;
  logic [C*W-1:0] duty;
  logic         frame_valid;
  logic [C-1:0] changed;

  always #5 clk = ~clk;

  pwm_capture #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .pwm_in     (pwm_in),
    .duty       (duty),
    .frame_valid(frame_valid),
    .changed    (changed)
  );

  int tests = 0;
  int fails = 0;

  // Stimulus history, one entry per rising edge.
  bit           h_rst[$];
  bit           h_en[$];
  logic [C-1:0] h_pwm[$];

  // Reference model state.
  int           run_len   = 0;
  logic [C*W-1:0] m_duty  = '0;
  logic [C-1:0] m_changed = '0;
  logic         m_fv      = 1'b0;

  // Stimulus generator state.
  int phase     = 0;
  int cfg[C];
  bit rand_mode = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [C-1:0] gen_pwm();
    logic [C-1:0] v;
    v = '0;
    for (int i = 0; i < C; i++) begin
      if (rand_mode) v[i] = ($urandom_range(0, C - 1) < i);
      else           v[i] = ((phase % P) < cfg[i]);
    end
    return v;
  endfunction

  // Sample the design sees at edge e: input from two edges earlier, unless a
  // reset edge cleared the synchronizer in between.
  function automatic int sample(int e, int ch);
    if (e < 2) return 0;
    if (h_rst[e-1] || h_rst[e-2]) return 0;
    return int'(h_pwm[e-2][ch]);
  endfunction

  task automatic model_update();
    int n;
    int sum;
    int nd;
    logic [C*W-1:0] next_duty;
    n = h_rst.size() - 1;
    m_fv = 1'b0;
    if (h_rst[n]) begin
      run_len   = 0;
      m_duty    = '0;
      m_changed = '0;
    end else if (!h_en[n]) begin
      run_len = 0;
    end else begin
      run_len++;
      // First edge only arms the block; a window then ends every P edges.
      if (run_len > 1 && (run_len - 1) % P == 0) begin
        next_duty = m_duty;
        for (int ch = 0; ch < C; ch++) begin
          sum = 0;
          for (int e = n - P + 1; e <= n; e++) sum += sample(e, ch);
          nd = (sum > P - 1) ? P - 1 : sum;
          m_changed[ch] = (W'(nd) != m_duty[ch*W +: W]);
          next_duty[ch*W +: W] = W'(nd);
        end
        m_duty = next_duty;
        m_fv   = 1'b1;
      end
    end
  endtask

  task automatic step(input bit r, input bit e);
    logic [C-1:0] p;
    p      = gen_pwm();
    rst    = r;
    enable = e;
    pwm_in = p;
    @(posedge clk);
    #1;
    phase++;
    h_rst.push_back(r);
    h_en.push_back(e);
    h_pwm.push_back(p);
    model_update();
    check("frame_valid", 64'(frame_valid), 64'(m_fv));
    check("duty", 64'(duty), 64'(m_duty));
    check("changed", 64'(changed), 64'(m_changed));
  endtask

  task automatic wait_frame(output int cnt);
    cnt = 0;
    do begin
      step(1'b0, 1'b1);
      cnt++;
    end while (!frame_valid && cnt < 300);
    if (!frame_valid) check("frame_timeout", 64'(frame_valid), 64'd1);
  endtask

  // Run enabled until the next edge will see the given window position.
  task automatic run_until_fc(input int target);
    int guard;
    guard = 0;
    while (!(run_len >= 1 && (run_len - 1) % P == target) && guard < 600) begin
      step(1'b0, 1'b1);
      guard++;
    end
    if (guard >= 600) check("fc_timeout", 64'(run_len), 64'(target + 1));
  endtask

  initial begin
    int cnt;
    logic [C*W-1:0] saved;

    rst = 1'b1; enable = 1'b0; pwm_in = '0;
    for (int i = 0; i < C; i++) cfg[i] = 0;

    // Reset values, then first-frame latency with idle inputs.
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
    check("rst_duty", 64'(duty), 64'd0);
    check("rst_changed", 64'(changed), 64'd0);
    check("rst_fv", 64'(frame_valid), 64'd0);
    wait_frame(cnt);
    check("first_latency", 64'(cnt), 64'd257);
    check("first_duty", 64'(duty), 64'd0);
    check("first_changed", 64'(changed), 64'd0);

    // Constant-high inputs saturate every lane.
    for (int i = 0; i < C; i++) cfg[i] = P;
    wait_frame(cnt);
    wait_frame(cnt);
    check("const_duty", 64'(duty), {64{1'b1}});
    check("const_changed", 64'(changed), 64'hFF);
    wait_frame(cnt);
    check("const_duty2", 64'(duty), {64{1'b1}});
    check("const_changed2", 64'(changed), 64'h00);

    // Generator loopback with a random phase offset.
    for (int i = 0; i < C; i++) cfg[i] = 32 * i;
    phase = int'($urandom_range(0, P - 1));
    wait_frame(cnt);
    wait_frame(cnt);
    for (int f = 0; f < 2; f++) begin
      wait_frame(cnt);
      check("loop_period", 64'(cnt), 64'd256);
      for (int i = 0; i < C; i++) check("loop_lane", 64'(duty[i*W +: W]), 64'(32 * i));
    end

    // Only channel 3 changes duty, mid-window.
    cfg[3] = 100;
    wait_frame(cnt);
    wait_frame(cnt);
    check("part_before", 64'(duty[3*W +: W]), 64'd100);
    run_until_fc(128);
    cfg[3] = 200;
    wait_frame(cnt);
    wait_frame(cnt);
    check("part_after", 64'(duty[3*W +: W]), 64'd200);
    check("part_changed", 64'(changed), 64'h08);
    wait_frame(cnt);
    check("part_settled", 64'(changed), 64'h00);

    // Disable mid-window for 50 clocks.
    run_until_fc(100);
    saved = duty;
    for (int k = 0; k < 50; k++) step(1'b0, 1'b0);
    check("dis_hold", 64'(duty), 64'(saved));
    wait_frame(cnt);
    check("dis_latency", 64'(cnt), 64'd257);
    for (int i = 0; i < C; i++) check("dis_lane", 64'(duty[i*W +: W]), 64'(cfg[i]));

    // Reset on the window-end cycle wins over enable.
    run_until_fc(255);
    step(1'b1, 1'b1);
    check("rp_fv", 64'(frame_valid), 64'd0);
    check("rp_duty", 64'(duty), 64'd0);
    check("rp_changed", 64'(changed), 64'd0);
    wait_frame(cnt);
    check("rp_latency", 64'(cnt), 64'd257);

    // Random per-channel-biased inputs with sporadic enable drops and a reset.
    rand_mode = 1'b1;
    for (int k = 0; k < 800; k++) step(1'b0, 1'b1);
    for (int k = 0; k < 300; k++)
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 29) != 0));
    wait_frame(cnt);
    wait_frame(cnt);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
